key_event_ctrl: RTL and testbench

Key event controller between the per-button debouncers and the user-control logic. It takes N debounced key levels, runs a press/hold/auto-repeat state machine per key, and queues press, repeat and release events. A rotating-priority arbiter drains those events onto a single valid/ready event port. The design runs at 50 MHz, so all counts below are in clk cycles.

---
 rtl/key_event_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: per-key press/hold/auto-repeat FSMs that queue events,
// drained by a rotating-priority arbiter onto one valid/ready port.
// Ports: clk, rst_n (async, active low); key_lvl (1 = released);
// evt_valid/evt_ready/evt_key/evt_type event port; key_held per key;
// ovf sticky merge/drop flag, ovf_clr clears it.
module key_event_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  localparam int IDXW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_lvl,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDXW-1:0]   evt_key,
  output logic [1:0]        evt_type,
  output logic [N_KEYS-1:0] key_held,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int MAXC =
    (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] LONG_M1 = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] REP_M1 = TW'(REPEAT_CYC - 1);
  localparam logic [IDXW:0] NK = (IDXW + 1)'(N_KEYS);
  localparam logic [IDXW-1:0] LAST = IDXW'(N_KEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REP
  } state_e;

  logic [N_KEYS-1:0] key_q;
  logic [N_KEYS-1:0] fall;
  logic [N_KEYS-1:0] rise;
  state_e            st_q  [N_KEYS];
  state_e            st_d  [N_KEYS];
  logic [TW-1:0]     tmr_q [N_KEYS];
  logic [TW-1:0]     tmr_d [N_KEYS];
  logic [N_KEYS-1:0] set_p, set_r, set_l;
  logic [N_KEYS-1:0] pp_q, pr_q, pl_q;
  logic [N_KEYS-1:0] pp_d, pr_d, pl_d;
  logic [N_KEYS-1:0] gnt_p, gnt_r, gnt_l;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [IDXW-1:0]   g_key, idx;
  logic [IDXW:0]     sum;
  logic [1:0]        g_type;
  logic              found, load, ovf_set;
  logic              evt_valid_q, ovf_q;
  logic [IDXW-1:0]   evt_key_q;
  logic [1:0]        evt_type_q;

  assign fall = key_q & ~key_lvl;
  assign rise = ~key_q & key_lvl;

  // Per-key FSM. A release beats a timer expiry in the same cycle.
  always_comb begin
    set_p = '0;
    set_r = '0;
    set_l = '0;
    key_held = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      st_d[k]  = st_q[k];
      tmr_d[k] = tmr_q[k];
      key_held[k] = (st_q[k] != S_IDLE);
      case (st_q[k])
        S_IDLE: begin
          if (fall[k]) begin
            st_d[k]  = S_HOLD;
            tmr_d[k] = '0;
            set_p[k] = 1'b1;
          end
        end
        S_HOLD: begin
          if (rise[k]) begin
            st_d[k]  = S_IDLE;
            tmr_d[k] = '0;
            set_l[k] = 1'b1;
          end else if (tmr_q[k] == LONG_M1) begin
            st_d[k]  = S_REP;
            tmr_d[k] = '0;
            set_r[k] = 1'b1;
          end else begin
            tmr_d[k] = tmr_q[k] + TW'(1);
          end
        end
        S_REP: begin
          if (rise[k]) begin
            st_d[k]  = S_IDLE;
            tmr_d[k] = '0;
            set_l[k] = 1'b1;
          end else if (tmr_q[k] == REP_M1) begin
            tmr_d[k] = '0;
            set_r[k] = 1'b1;
          end else begin
            tmr_d[k] = tmr_q[k] + TW'(1);
          end
        end
        default: begin
          st_d[k]  = S_IDLE;
          tmr_d[k] = '0;
        end
      endcase
    end
  end

  // Rotating scan from rr_q; press > repeat > release within a key.
  always_comb begin
    found  = 1'b0;
    g_key  = '0;
    g_type = 2'd0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      sum = {1'b0, rr_q} + (IDXW + 1)'(i);
      if (sum >= NK) sum = sum - NK;
      idx = sum[IDXW-1:0];
      if (!found && (pp_q[idx] | pr_q[idx] | pl_q[idx])) begin
        found = 1'b1;
        g_key = idx;
        if (pp_q[idx])      g_type = 2'd0;
        else if (pr_q[idx]) g_type = 2'd1;
        else                g_type = 2'd2;
      end
    end
  end

  assign load = ~evt_valid_q | evt_ready;
  assign rr_d = (g_key == LAST) ? '0 : g_key + IDXW'(1);

  always_comb begin
    gnt_p = '0;
    gnt_r = '0;
    gnt_l = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (load && found && g_key == IDXW'(k)) begin
        gnt_p[k] = (g_type == 2'd0);
        gnt_r[k] = (g_type == 2'd1);
        gnt_l[k] = (g_type == 2'd2);
      end
    end
  end

  // A set on a bit granted in the same cycle re-arms it without overflow.
  assign pp_d = (pp_q & ~gnt_p) | set_p;
  assign pr_d = (pr_q & ~gnt_r) | set_r;
  assign pl_d = (pl_q & ~gnt_l) | set_l;
  assign ovf_set = |((set_p & pp_q & ~gnt_p) |
                     (set_r & pr_q & ~gnt_r) |
                     (set_l & pl_q & ~gnt_l));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '1;
      pp_q        <= '0;
      pr_q        <= '0;
      pl_q        <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= 2'd0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]  <= S_IDLE;
        tmr_q[k] <= '0;
      end
    end else begin
      key_q <= key_lvl;
      pp_q  <= pp_d;
      pr_q  <= pr_d;
      pl_q  <= pl_d;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]  <= st_d[k];
        tmr_q[k] <= tmr_d[k];
      end
      if (load) begin
        if (found) begin
          evt_valid_q <= 1'b1;
          evt_key_q   <= g_key;
          evt_type_q  <= g_type;
          rr_q        <= rr_d;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed vector table plus hand-written sequences
// for key_event_ctrl with N_KEYS=4, LONG_CYC=8, REPEAT_CYC=4.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_lvl = 4'hF;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic [3:0] key_held;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(
    .N_KEYS(4),
    .LONG_CYC(8),
    .REPEAT_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_lvl(key_lvl),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_type(evt_type),
    .key_held(key_held),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [3:0] lvl;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] k;
    logic [1:0] t;
    logic [3:0] h;
    logic       o;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] lvl, input logic rdy,
                     input logic clr, input logic v, input logic [1:0] k,
                     input logic [1:0] t, input logic [3:0] h,
                     input logic o);
    vec_t e;
    e.lvl = lvl; e.rdy = rdy; e.clr = clr; e.v = v;
    e.k = k; e.t = t; e.h = h; e.o = o;
    vq.push_back(e);
  endtask

  task automatic run_vecs(input string nm);
    foreach (vq[i]) begin
      key_lvl   = vq[i].lvl;
      evt_ready = vq[i].rdy;
      ovf_clr   = vq[i].clr;
      step();
      chk($sformatf("%s[%0d].valid", nm, i), evt_valid, vq[i].v);
      if (vq[i].v) begin
        chk($sformatf("%s[%0d].key", nm, i), evt_key, vq[i].k);
        chk($sformatf("%s[%0d].type", nm, i), evt_type, vq[i].t);
      end
      chk($sformatf("%s[%0d].held", nm, i), key_held, vq[i].h);
      chk($sformatf("%s[%0d].ovf", nm, i), ovf, vq[i].o);
    end
    vq.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, evt_valid, 0);
    chk({nm, ".key"}, evt_key, 0);
    chk({nm, ".type"}, evt_type, 0);
    chk({nm, ".held"}, key_held, 0);
    chk({nm, ".ovf"}, ovf, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_lvl = 4'hF;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bp_chk(input string nm, input logic v,
                        input logic [1:0] k, input logic [1:0] t);
    chk({nm, ".valid"}, evt_valid, v);
    if (v) begin
      chk({nm, ".key"}, evt_key, k);
      chk({nm, ".type"}, evt_type, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Long hold of key0, released at edge 20.
    for (int i = 0; i < 23; i++) begin
      add((i < 20) ? 4'hE : 4'hF, 1'b1, 1'b0,
          (i == 1 || i == 9 || i == 13 || i == 17 || i == 21),
          2'd0,
          (i == 1) ? 2'd0 : ((i == 21) ? 2'd2 : 2'd1),
          (i < 20) ? 4'h1 : 4'h0, 1'b0);
    end
    run_vecs("hold");

    // All keys pressed together, then released together.
    do_reset();
    add(4'h0, 1, 0, 0, 0, 0, 4'hF, 0);
    add(4'h0, 1, 0, 1, 0, 0, 4'hF, 0);
    add(4'h0, 1, 0, 1, 1, 0, 4'hF, 0);
    add(4'h0, 1, 0, 1, 2, 0, 4'hF, 0);
    add(4'h0, 1, 0, 1, 3, 0, 4'hF, 0);
    add(4'h0, 1, 0, 0, 0, 0, 4'hF, 0);
    add(4'hF, 1, 0, 0, 0, 0, 4'h0, 0);
    add(4'hF, 1, 0, 1, 0, 2, 4'h0, 0);
    add(4'hF, 1, 0, 1, 1, 2, 4'h0, 0);
    add(4'hF, 1, 0, 1, 2, 2, 4'h0, 0);
    add(4'hF, 1, 0, 1, 3, 2, 4'h0, 0);
    add(4'hF, 1, 0, 0, 0, 0, 4'h0, 0);
    run_vecs("simul");

    // Backpressure on a key2 press.
    do_reset();
    key_lvl = 4'hB;
    evt_ready = 1'b0;
    step();
    chk("bp.e0.valid", evt_valid, 0);
    chk("bp.e0.held", key_held, 4'h4);
    step();
    bp_chk("bp.e1", 1, 2, 0);
    key_lvl = 4'hF;
    for (int j = 2; j <= 10; j++) begin
      step();
      bp_chk($sformatf("bp.e%0d", j), 1, 2, 0);
    end
    chk("bp.held_rel", key_held, 0);
    evt_ready = 1'b1;
    step();
    bp_chk("bp.e11", 1, 2, 2);
    evt_ready = 1'b0;
    step();
    bp_chk("bp.e12", 1, 2, 2);
    evt_ready = 1'b1;
    step();
    chk("bp.e13.valid", evt_valid, 0);

    // Short tap of key3 while the consumer is stalled.
    evt_ready = 1'b0;
    key_lvl = 4'h7;
    step();
    chk("tap.e0.valid", evt_valid, 0);
    chk("tap.e0.held", key_held, 4'h8);
    step();
    bp_chk("tap.e1", 1, 3, 0);
    step();
    key_lvl = 4'hF;
    step();
    chk("tap.e3.held", key_held, 0);
    step();
    bp_chk("tap.e4", 1, 3, 0);
    evt_ready = 1'b1;
    step();
    bp_chk("tap.e5", 1, 3, 2);
    step();
    chk("tap.e6.valid", evt_valid, 0);
    chk("tap.ovf", ovf, 0);

    // Overflow: a second key1 press merges into the pending one.
    do_reset();
    key_lvl = 4'hE;
    step();
    key_lvl = 4'hF;
    step();
    bp_chk("ovf.e1", 1, 0, 0);
    key_lvl = 4'hD;
    step();
    key_lvl = 4'hF;
    step();
    chk("ovf.e3.ovf", ovf, 0);
    key_lvl = 4'hD;
    step();
    chk("ovf.e4.ovf", ovf, 1);
    key_lvl = 4'hF;
    step();
    ovf_clr = 1'b1;
    step();
    chk("ovf.clr.ovf", ovf, 0);
    key_lvl = 4'hD;
    step();
    chk("ovf.clr_race.ovf", ovf, 1);
    ovf_clr = 1'b0;
    key_lvl = 4'hF;
    step();
    chk("ovf.e8.ovf", ovf, 1);
    bp_chk("ovf.e8", 1, 0, 0);
    evt_ready = 1'b1;
    step();
    bp_chk("ovf.e9", 1, 1, 0);
    step();
    bp_chk("ovf.e10", 1, 0, 2);
    step();
    bp_chk("ovf.e11", 1, 1, 2);
    step();
    chk("ovf.e12.valid", evt_valid, 0);
    chk("ovf.e12.ovf", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf.e13.ovf", ovf, 0);

    // Reset while key0 is in auto-repeat with an event pending.
    do_reset();
    key_lvl = 4'hE;
    for (int j = 0; j <= 9; j++) step();
    bp_chk("rst.pre", 1, 0, 0);
    chk("rst.pre.held", key_held, 4'h1);
    #1;
    rst_n = 1'b0;
    evt_ready = 1'b1;
    #1;
    chk_zero("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst.r0.valid", evt_valid, 0);
    chk("rst.r0.held", key_held, 4'h1);
    step();
    bp_chk("rst.r1", 1, 0, 0);
    for (int j = 2; j <= 8; j++) begin
      step();
      chk($sformatf("rst.r%0d.valid", j), evt_valid, 0);
    end
    step();
    bp_chk("rst.r9", 1, 0, 1);
    key_lvl = 4'hF;
    step();
    step();
    bp_chk("rst.rel", 1, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
